// File: rtl/pir_alarm_qualifier.sv
// PIR alarm qualifier: per-zone threshold/debounce qualification feeding an
// arm/alarm state machine. All outputs are registered.
module pir_alarm_qualifier #(
  parameter int THRESH         = 20,
  parameter int CONFIRM_CYCLES = 3,
  parameter int ARM_DELAY      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       turn,
  input  logic       stop_alarm,
  input  logic [6:0] pir_sensor_1,
  input  logic [6:0] pir_sensor_2,
  input  logic [6:0] pir_sensor_3,
  output logic       armed,
  output logic       alarm,
  output logic [2:0] zone_mask,
  output logic       motion_event,
  output logic [7:0] event_count
);

  localparam logic [6:0] THRESH_C  = 7'(THRESH);
  localparam logic [3:0] CONFIRM_C = 4'(CONFIRM_CYCLES);
  localparam logic [7:0] DELAY_C   = 8'(ARM_DELAY);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_ALARM    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_arm_cnt;
  logic [7:0]      w_arm_cnt_nxt;
  logic [7:0]      w_arm_inc;
  logic [2:0][3:0] r_zone_cnt;
  logic [2:0][3:0] w_zone_cnt_nxt;
  logic [2:0][3:0] w_zone_inc;
  logic [2:0][6:0] w_sample;
  logic [2:0]      w_hit;
  logic [2:0]      w_qual;
  logic            w_zone_run;
  logic            w_zone_keep;

  logic            r_armed;
  logic            r_alarm;
  logic [2:0]      r_zone_mask;
  logic            r_motion_event;
  logic [7:0]      r_event_count;
  logic            w_armed_nxt;
  logic            w_alarm_nxt;
  logic [2:0]      w_zone_mask_nxt;
  logic            w_motion_nxt;
  logic [7:0]      w_event_count_nxt;

  assign w_sample    = {pir_sensor_3, pir_sensor_2, pir_sensor_1};
  assign w_arm_inc   = r_arm_cnt + 8'd1;
  assign w_zone_run  = (r_state == ST_ARMED) || (r_state == ST_ALARM);
  assign w_zone_keep = w_zone_run &&
                       ((w_state_nxt == ST_ARMED) || (w_state_nxt == ST_ALARM));

  // Qualification only fires on the edge a counter first reaches CONFIRM.
  always_comb begin
    w_hit      = 3'b000;
    w_qual     = 3'b000;
    w_zone_inc = '0;
    for (int n = 0; n < 3; n++) begin
      w_hit[n] = (w_sample[n] >= THRESH_C);
      if (r_zone_cnt[n] == CONFIRM_C) begin
        w_zone_inc[n] = r_zone_cnt[n];
      end else begin
        w_zone_inc[n] = r_zone_cnt[n] + 4'd1;
      end
      w_qual[n] = w_zone_run && w_hit[n] &&
                  (r_zone_cnt[n] != CONFIRM_C) && (w_zone_inc[n] == CONFIRM_C);
    end
  end

  always_comb begin
    w_zone_cnt_nxt = '0;
    for (int n = 0; n < 3; n++) begin
      if (w_zone_keep && w_hit[n]) begin
        w_zone_cnt_nxt[n] = w_zone_inc[n];
      end else begin
        w_zone_cnt_nxt[n] = 4'd0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!turn) begin
      w_state_nxt = ST_DISARMED;
    end else begin
      case (r_state)
        ST_DISARMED: w_state_nxt = ST_ARMING;
        ST_ARMING: begin
          if (w_arm_inc == DELAY_C) begin
            w_state_nxt = ST_ARMED;
          end else begin
            w_state_nxt = ST_ARMING;
          end
        end
        ST_ARMED: begin
          if (|w_qual) begin
            w_state_nxt = ST_ALARM;
          end else begin
            w_state_nxt = ST_ARMED;
          end
        end
        ST_ALARM: begin
          if (stop_alarm) begin
            w_state_nxt = ST_ARMING;
          end else begin
            w_state_nxt = ST_ALARM;
          end
        end
        default: w_state_nxt = ST_DISARMED;
      endcase
    end
  end

  // Exit-delay counter restarts from 0 on every entry into ARMING.
  always_comb begin
    w_arm_cnt_nxt = 8'd0;
    if ((r_state == ST_ARMING) && (w_state_nxt == ST_ARMING)) begin
      w_arm_cnt_nxt = w_arm_inc;
    end else begin
      w_arm_cnt_nxt = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_DISARMED;
      r_arm_cnt  <= 8'd0;
      r_zone_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_arm_cnt  <= w_arm_cnt_nxt;
      r_zone_cnt <= w_zone_cnt_nxt;
    end
  end

  always_comb begin
    w_armed_nxt       = (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_ALARM);
    w_alarm_nxt       = (w_state_nxt == ST_ALARM);
    w_motion_nxt      = (r_state == ST_ARMED) && (w_state_nxt == ST_ALARM);
    w_zone_mask_nxt   = 3'b000;
    w_event_count_nxt = r_event_count;
    if (w_motion_nxt) begin
      w_zone_mask_nxt = w_qual;
    end else if ((r_state == ST_ALARM) && (w_state_nxt == ST_ALARM)) begin
      w_zone_mask_nxt = r_zone_mask | w_qual;
    end else begin
      w_zone_mask_nxt = 3'b000;
    end
    if (w_motion_nxt && (r_event_count != 8'd255)) begin
      w_event_count_nxt = r_event_count + 8'd1;
    end else begin
      w_event_count_nxt = r_event_count;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_armed        <= 1'b0;
      r_alarm        <= 1'b0;
      r_zone_mask    <= 3'b000;
      r_motion_event <= 1'b0;
      r_event_count  <= 8'd0;
    end else begin
      r_armed        <= w_armed_nxt;
      r_alarm        <= w_alarm_nxt;
      r_zone_mask    <= w_zone_mask_nxt;
      r_motion_event <= w_motion_nxt;
      r_event_count  <= w_event_count_nxt;
    end
  end

  assign armed        = r_armed;
  assign alarm        = r_alarm;
  assign zone_mask    = r_zone_mask;
  assign motion_event = r_motion_event;
  assign event_count  = r_event_count;

endmodule

// File: tb/tb_pir_alarm_qualifier.sv
// Scoreboard bench for pir_alarm_qualifier: the driver queues the expected
// outputs for each edge, a monitor pops and compares #1 after that edge.
module tb_pir_alarm_qualifier;

  logic       clk;
  logic       rst_n;
  logic       turn;
  logic       stop_alarm;
  logic [6:0] pir_sensor_1;
  logic [6:0] pir_sensor_2;
  logic [6:0] pir_sensor_3;
  logic       armed;
  logic       alarm;
  logic [2:0] zone_mask;
  logic       motion_event;
  logic [7:0] event_count;

  logic [13:0] exp_q[$];
  string       name_q[$];
  logic [7:0]  exp_cnt;
  int          n_cmp;
  int          n_err;

  pir_alarm_qualifier #(
    .THRESH(20),
    .CONFIRM_CYCLES(3),
    .ARM_DELAY(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .turn(turn),
    .stop_alarm(stop_alarm),
    .pir_sensor_1(pir_sensor_1),
    .pir_sensor_2(pir_sensor_2),
    .pir_sensor_3(pir_sensor_3),
    .armed(armed),
    .alarm(alarm),
    .zone_mask(zone_mask),
    .motion_event(motion_event),
    .event_count(event_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor: one expected entry per edge, compared just after that edge.
  initial begin
    logic [13:0] e;
    logic [13:0] act;
    string       nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {armed, alarm, zone_mask, motion_event, event_count};
        n_cmp++;
        if (act !== e) begin
          n_err++;
          $display("FAIL %s: got armed=%b alarm=%b mask=%b motion=%b count=%0d, want armed=%b alarm=%b mask=%b motion=%b count=%0d",
                   nm, act[13], act[12], act[11:9], act[8], act[7:0],
                   e[13], e[12], e[11:9], e[8], e[7:0]);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic t, input logic s,
                      input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3,
                      input logic ea, input logic eal, input logic [2:0] em,
                      input logic emo, input string nm);
    @(negedge clk);
    rst_n        = rst;
    turn         = t;
    stop_alarm   = s;
    pir_sensor_1 = p1;
    pir_sensor_2 = p2;
    pir_sensor_3 = p3;
    if (!rst) begin
      exp_cnt = 8'd0;
    end else if (emo && (exp_cnt != 8'd255)) begin
      exp_cnt = exp_cnt + 8'd1;
    end
    exp_q.push_back({ea, eal, em, emo, exp_cnt});
    name_q.push_back(nm);
  endtask

  // Remainder of ARMING after the entry edge: 7 more idle edges, then ARMED.
  task automatic arming_rest(input int stop_at, input string nm);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, (i == stop_at), 7'd0, 7'd0, 7'd0,
           1'b0, 1'b0, 3'b000, 1'b0, nm);
    end
    step(1'b1, 1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 1'b1, 1'b0, 3'b000, 1'b0, {nm, "_armed"});
  endtask

  initial begin
    int w;
    n_cmp        = 0;
    n_err        = 0;
    exp_cnt      = 8'd0;
    rst_n        = 1'b0;
    turn         = 1'b0;
    stop_alarm   = 1'b0;
    pir_sensor_1 = 7'd0;
    pir_sensor_2 = 7'd0;
    pir_sensor_3 = 7'd0;

    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)),
           7'($urandom_range(127)), 7'($urandom_range(127)), 7'($urandom_range(127)),
           1'b0, 1'b0, 3'b000, 1'b0, "reset");
    end

    step(1'b1, 1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 3'b000, 1'b0, "t2_entry");
    arming_rest(-1, "t2_arming");
    step(1'b1, 1'b1, 1'b0, 7'd29, 7'd0, 7'd56, 1'b1, 1'b0, 3'b000, 1'b0, "t2_conf1");
    step(1'b1, 1'b1, 1'b0, 7'd29, 7'd0, 7'd56, 1'b1, 1'b0, 3'b000, 1'b0, "t2_conf2");
    step(1'b1, 1'b1, 1'b0, 7'd29, 7'd0, 7'd56, 1'b1, 1'b1, 3'b101, 1'b1, "t2_alarm");
    step(1'b1, 1'b1, 1'b0, 7'd29, 7'd0, 7'd56, 1'b1, 1'b1, 3'b101, 1'b0, "t2_hold1");
    step(1'b1, 1'b1, 1'b0, 7'd29, 7'd0, 7'd56, 1'b1, 1'b1, 3'b101, 1'b0, "t2_hold2");

    step(1'b1, 1'b1, 1'b1, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 3'b000, 1'b0, "t3_stop");
    arming_rest(3, "t3_arming");

    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, (i == 5), 7'd0, 7'd19, 7'd0, 1'b1, 1'b0, 3'b000, 1'b0, "t4_below");
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 7'd0, 7'd20, 7'd0, 1'b1, 1'b0, 3'b000, 1'b0, "t4_pat_a");
      step(1'b1, 1'b1, 1'b0, 7'd0, 7'd20, 7'd0, 1'b1, 1'b0, 3'b000, 1'b0, "t4_pat_b");
      step(1'b1, 1'b1, 1'b0, 7'd0, 7'd0,  7'd0, 1'b1, 1'b0, 3'b000, 1'b0, "t4_pat_c");
    end
    step(1'b1, 1'b1, 1'b0, 7'd0, 7'd90, 7'd0, 1'b1, 1'b0, 3'b000, 1'b0, "t4_conf1");
    step(1'b1, 1'b1, 1'b0, 7'd0, 7'd90, 7'd0, 1'b1, 1'b0, 3'b000, 1'b0, "t4_conf2");
    step(1'b1, 1'b1, 1'b0, 7'd0, 7'd90, 7'd0, 1'b1, 1'b1, 3'b010, 1'b1, "t4_alarm");
    step(1'b1, 1'b1, 1'b0, 7'd0, 7'd90, 7'd0, 1'b1, 1'b1, 3'b010, 1'b0, "t4_no_repulse");

    step(1'b1, 1'b0, 1'b1, 7'd0, 7'd90, 7'd0, 1'b0, 1'b0, 3'b000, 1'b0, "t5_turn_off");
    step(1'b1, 1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 3'b000, 1'b0, "t5_entry");
    arming_rest(-1, "t5_arming");
    step(1'b1, 1'b1, 1'b0, 7'd30, 7'd0,  7'd0, 1'b1, 1'b0, 3'b000, 1'b0, "t5_a1");
    step(1'b1, 1'b1, 1'b0, 7'd30, 7'd30, 7'd0, 1'b1, 1'b0, 3'b000, 1'b0, "t5_a2");
    step(1'b1, 1'b1, 1'b0, 7'd30, 7'd30, 7'd0, 1'b1, 1'b1, 3'b001, 1'b1, "t5_alarm");
    step(1'b1, 1'b1, 1'b0, 7'd30, 7'd30, 7'd0, 1'b1, 1'b1, 3'b011, 1'b0, "t5_or_in");
    step(1'b1, 1'b1, 1'b1, 7'd0,  7'd0,  7'd0, 1'b0, 1'b0, 3'b000, 1'b0, "t5_stop");
    arming_rest(-1, "t5_rearm");

    step(1'b1, 1'b1, 1'b0, 7'd30, 7'd0,  7'd0, 1'b1, 1'b0, 3'b000, 1'b0, "t6_a1");
    step(1'b1, 1'b1, 1'b0, 7'd30, 7'd30, 7'd0, 1'b1, 1'b0, 3'b000, 1'b0, "t6_a2");
    step(1'b1, 1'b1, 1'b0, 7'd30, 7'd30, 7'd0, 1'b1, 1'b1, 3'b001, 1'b1, "t6_alarm");
    step(1'b1, 1'b1, 1'b1, 7'd30, 7'd30, 7'd0, 1'b0, 1'b0, 3'b000, 1'b0, "t6_stop_wins");
    arming_rest(-1, "t6_arming");

    for (int k = 0; k < 254; k++) begin
      step(1'b1, 1'b1, 1'b0, 7'd127, 7'd0, 7'd0, 1'b1, 1'b0, 3'b000, 1'b0, "sat_c1");
      step(1'b1, 1'b1, 1'b0, 7'd127, 7'd0, 7'd0, 1'b1, 1'b0, 3'b000, 1'b0, "sat_c2");
      step(1'b1, 1'b1, 1'b0, 7'd127, 7'd0, 7'd0, 1'b1, 1'b1, 3'b001, 1'b1, "sat_alarm");
      step(1'b1, 1'b1, 1'b1, 7'd0,   7'd0, 7'd0, 1'b0, 1'b0, 3'b000, 1'b0, "sat_stop");
      arming_rest(-1, "sat_arming");
    end

    step(1'b1, 1'b1, 1'b0, 7'd0, 7'd0, 7'd127, 1'b1, 1'b0, 3'b000, 1'b0, "rst_c1");
    step(1'b1, 1'b1, 1'b0, 7'd0, 7'd0, 7'd127, 1'b1, 1'b0, 3'b000, 1'b0, "rst_c2");
    step(1'b1, 1'b1, 1'b0, 7'd0, 7'd0, 7'd127, 1'b1, 1'b1, 3'b100, 1'b1, "rst_alarm_at_255");
    step(1'b0, 1'b1, 1'b0, 7'd0, 7'd0, 7'd127, 1'b0, 1'b0, 3'b000, 1'b0, "reset_mid_alarm");
    step(1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0,   1'b0, 1'b0, 3'b000, 1'b0, "post_reset_idle");

    w = 0;
    while ((exp_q.size() > 0) && (w < 10)) begin
      @(posedge clk);
      w++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
